// File: rtl/multi_clkdiv.sv
// Purpose : N_CH independent programmable clock/tick dividers with glitch-free period reload.
// Latency : outputs are registered; a new divisor takes effect on the channel's next wrap edge.
// Backpressure: none; loads are always accepted (a reload before the apply overwrites the shadow).
//
// Ports:
//    iCLK   system clock, rising edge          RSTB   async active-low reset
//    iEN    global run enable                  iMODE  per-channel mode (0 square, 1 pulse)
//    iLOAD  divisor write strobe               iCH    channel index for iLOAD
//    iDIV   new period in iCLK cycles          oCLK   per-channel divided clock / pulse
//    oTICK  per-channel period-end strobe      oPEND  per-channel reload-pending flag
module multi_clkdiv #(
   parameter int CNT_W       = 16,
   parameter int CH_W        = 1,
   parameter int DEFAULT_DIV = 1500,
   localparam int N_CH       = 2 ** CH_W
) (
   input  logic              iCLK,
   input  logic              RSTB,
   input  logic              iEN,
   input  logic [N_CH-1:0]   iMODE,
   input  logic              iLOAD,
   input  logic [CH_W-1:0]   iCH,
   input  logic [CNT_W-1:0]  iDIV,
   output logic [N_CH-1:0]   oCLK,
   output logic [N_CH-1:0]   oTICK,
   output logic [N_CH-1:0]   oPEND
);

   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [CNT_W-1:0] a_q   [N_CH];
   logic [CNT_W-1:0] a_d   [N_CH];
   logic [CNT_W-1:0] s_q   [N_CH];
   logic [CNT_W-1:0] s_d   [N_CH];
   logic [N_CH-1:0]  pend_q, pend_d;
   logic [N_CH-1:0]  clk_q,  clk_d;
   logic [N_CH-1:0]  tick_q, tick_d;

   logic [N_CH-1:0]  wrap;
   logic [CNT_W-1:0] div_clamped;
   logic             ld_ok;

   always_comb begin
      // Periods below 2 cannot produce a square wave, so they are raised to 2.
      div_clamped = (iDIV < CNT_W'(2)) ? CNT_W'(2) : iDIV;
      // Only matters when N_CH is not a power of two.
      ld_ok       = iLOAD && (int'(iCH) < N_CH);

      cnt_d  = cnt_q;
      a_d    = a_q;
      s_d    = s_q;
      pend_d = pend_q;
      clk_d  = '0;
      tick_d = '0;
      wrap   = '0;

      for (int c = 0; c < N_CH; c++) begin
         // With iEN low the counter is held at 0, so every edge is a wrap edge
         // and a pending divisor is applied right away.
         if (!iEN || (cnt_q[c] == a_q[c] - CNT_W'(1))) begin
            cnt_d[c] = '0;
         end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end
         wrap[c]   = (cnt_d[c] == '0);

         tick_d[c] = iEN && wrap[c];
         // Square: low for floor(A/2) cycles, high for the rest (odd A favours high).
         clk_d[c]  = iEN && (iMODE[c] ? wrap[c] : (cnt_d[c] >= (a_q[c] >> 1)));

         // Apply the shadow only at a period boundary so A never changes mid-period.
         if (wrap[c] && pend_q[c]) begin
            a_d[c]    = s_q[c];
            pend_d[c] = 1'b0;
         end
         // A load on the same edge as an apply lands in the shadow after the
         // old shadow has been consumed, so it waits for the following wrap.
         if (ld_ok && (int'(iCH) == c)) begin
            s_d[c]    = div_clamped;
            pend_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge iCLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c] <= '0;
            a_q[c]   <= CNT_W'(DEFAULT_DIV);
            s_q[c]   <= CNT_W'(DEFAULT_DIV);
         end
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
            a_q[c]   <= a_d[c];
            s_q[c]   <= s_d[c];
         end
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign oCLK  = clk_q;
   assign oTICK = tick_q;
   assign oPEND = pend_q;

endmodule

// File: tb/tb_multi_clkdiv.sv
// Purpose : directed checks of multi_clkdiv (2 channels, 16-bit, default period 1500).
// Latency : each vector is one clock edge; outputs sampled 1 ns after the edge.
// Backpressure: n/a.
module tb_multi_clkdiv;

   logic        iCLK = 1'b0;
   logic        RSTB;
   logic        iEN;
   logic [1:0]  iMODE;
   logic        iLOAD;
   logic [0:0]  iCH;
   logic [15:0] iDIV;
   logic [1:0]  oCLK, oTICK, oPEND;

   int checks = 0;
   int errors = 0;

   multi_clkdiv #(.CNT_W(16), .CH_W(1), .DEFAULT_DIV(1500)) dut (
      .iCLK (iCLK),
      .RSTB (RSTB),
      .iEN  (iEN),
      .iMODE(iMODE),
      .iLOAD(iLOAD),
      .iCH  (iCH),
      .iDIV (iDIV),
      .oCLK (oCLK),
      .oTICK(oTICK),
      .oPEND(oPEND)
   );

   always #10 iCLK = ~iCLK;

   typedef struct {
      int          seg;
      logic        en;
      logic [1:0]  mode;
      logic        ld;
      logic [0:0]  ch;
      logic [15:0] div;
      logic [1:0]  clk;
      logic [1:0]  tick;
      logic [1:0]  pend;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int seg, input logic en, input logic [1:0] mode, input logic ld,
                      input logic [0:0] ch, input int div,
                      input logic [1:0] c, input logic [1:0] t, input logic [1:0] p);
      vec_t v;
      v.seg = seg; v.en = en; v.mode = mode; v.ld = ld; v.ch = ch;
      v.div = 16'(div); v.clk = c; v.tick = t; v.pend = p;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic run_seg(input int seg);
      int row = 0;
      foreach (vecs[i]) begin
         if (vecs[i].seg == seg) begin
            iEN   = vecs[i].en;
            iMODE = vecs[i].mode;
            iLOAD = vecs[i].ld;
            iCH   = vecs[i].ch;
            iDIV  = vecs[i].div;
            step();
            check($sformatf("seg%0d row%0d clk/tick/pend", seg, row),
                  32'({oCLK, oTICK, oPEND}),
                  32'({vecs[i].clk, vecs[i].tick, vecs[i].pend}));
            row++;
         end
      end
      iLOAD = 1'b0;
   endtask

   // Steps with the current inputs until oTICK[ch] fires or the budget runs out.
   task automatic wait_tick(input int ch, input int budget, output int n, output bit pend_held);
      n = 0;
      pend_held = 1'b1;
      iLOAD = 1'b0;
      do begin
         step();
         n++;
         if (!oTICK[ch] && !oPEND[ch]) pend_held = 1'b0;
      end while (!oTICK[ch] && n < budget);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_tick0, first_high0, ticks0, ticks1, high0, high1, pend_seen, n;
      bit ph;

      // ---------------- vector table ----------------
      // seg0: load ch0 period 4 mid-period
      add(0, 1, 2'b00, 1, 0, 4, 2'b00, 2'b00, 2'b01);
      // seg1: ch0 at A=4 right after apply; ch1 still 1500; then load ch1 period 5
      add(1, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(1, 1, 2'b00, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(1, 1, 2'b00, 1, 1, 5, 2'b00, 2'b00, 2'b10);
      // seg2: ch0 A=4, ch1 A=5 square (3 high / 2 low)
      add(2, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b00, 2'b10, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b10, 2'b00, 2'b00);
      add(2, 1, 2'b00, 0, 0, 0, 2'b01, 2'b10, 2'b00);
      // ch1 switched to pulse mode
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b11, 2'b10, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b10, 2'b11, 2'b00);
      // ch0 loads of 1 and 0 both clamp to period 2
      add(2, 1, 2'b10, 1, 0, 1, 2'b00, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 1, 0, 0, 2'b11, 2'b10, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b10, 2'b11, 2'b00);
      // ch0 -> 6; with 8 pending, load 3 on a wrap edge: 8 applies there, 3 one period later
      add(2, 1, 2'b10, 1, 0, 6, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 1, 0, 8, 2'b00, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b11, 2'b10, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 1, 0, 3, 2'b00, 2'b01, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b10, 2'b10, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b11, 2'b10, 2'b01);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b01, 2'b00);
      // iEN low for 10 edges, ch0 load of 10 applies one edge later
      add(2, 0, 2'b10, 0, 0, 0,  2'b00, 2'b00, 2'b00);
      add(2, 0, 2'b10, 1, 0, 10, 2'b00, 2'b00, 2'b01);
      for (int k = 0; k < 8; k++) add(2, 0, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      // iEN high: ch0 restarts from 0 with A=10, ch1 pulse A=5
      for (int k = 0; k < 4; k++) add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b11, 2'b10, 2'b00);
      for (int k = 0; k < 4; k++) add(2, 1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      add(2, 1, 2'b10, 0, 0, 0, 2'b10, 2'b11, 2'b00);
      for (int k = 0; k < 4; k++) add(2, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      add(2, 1, 2'b10, 1, 1, 7, 2'b11, 2'b10, 2'b10);

      // ---------------- reset and default period ----------------
      RSTB = 1'b0; iEN = 1'b1; iMODE = 2'b00; iLOAD = 1'b0; iCH = 1'b0; iDIV = 16'd0;
      step();
      step();
      check("reset outputs", 32'({oCLK, oTICK, oPEND}), 32'd0);
      RSTB = 1'b1;

      first_tick0 = 0; first_high0 = 0; ticks0 = 0; ticks1 = 0;
      high0 = 0; high1 = 0; pend_seen = 0;
      for (int e = 1; e <= 3200; e++) begin
         step();
         if (oTICK[0] && first_tick0 == 0) first_tick0 = e;
         if (oCLK[0] && first_high0 == 0) first_high0 = e;
         if (oTICK[0]) ticks0++;
         if (oTICK[1]) ticks1++;
         if (e <= 3000 && oCLK[0]) high0++;
         if (e <= 3000 && oCLK[1]) high1++;
         if (oPEND != 2'b00) pend_seen++;
      end
      check("default first tick edge", 32'(first_tick0), 32'd1500);
      check("default first high edge", 32'(first_high0), 32'd750);
      check("default tick count ch0", 32'(ticks0), 32'd2);
      check("default tick count ch1", 32'(ticks1), 32'd2);
      check("default high cycles ch0", 32'(high0), 32'd1500);
      check("default high cycles ch1", 32'(high1), 32'd1500);
      check("default pend never set", 32'(pend_seen), 32'd0);

      // ---------------- ch0 reload to 4 ----------------
      run_seg(0);
      wait_tick(0, 1400, n, ph);
      check("ch0 reload wrap distance", 32'(n), 32'd1299);
      check("ch0 pend held until wrap", 32'(ph), 32'd1);
      check("ch0 reload wrap ticks", 32'(oTICK), 32'b11);
      check("ch0 pend cleared at wrap", 32'(oPEND), 32'b00);
      run_seg(1);

      // ---------------- ch1 reload to 5 ----------------
      wait_tick(1, 1600, n, ph);
      check("ch1 reload wrap distance", 32'(n), 32'd1491);
      check("ch1 pend held until wrap", 32'(ph), 32'd1);
      check("ch1 reload wrap ticks", 32'(oTICK), 32'b11);
      check("ch1 pend cleared at wrap", 32'(oPEND), 32'b00);
      run_seg(2);

      // ---------------- async reset mid-period ----------------
      iEN = 1'b1; iMODE = 2'b00; iLOAD = 1'b0;
      #4;
      RSTB = 1'b0;
      #1;
      check("async reset outputs", 32'({oCLK, oTICK, oPEND}), 32'd0);
      step();
      RSTB = 1'b1;
      wait_tick(0, 1600, n, ph);
      check("post-reset first tick edge", 32'(n), 32'd1500);
      check("post-reset ticks both", 32'(oTICK), 32'b11);
      check("post-reset pend", 32'(oPEND), 32'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
